keccak_feeder: RTL and testbench
================================

// Module: keccak_feeder
// PURPOSE
//  Transmit side of the keccak core's 32-bit message-input interface (in/in_ready/is_last/byte_num/buffer_full).
//  Accepts a byte stream from a host over valid/ready and packs it big-endian into 32-bit words.
//  Drives each word to the core, stalling while buffer_full=1, and closes the message with a correct is_last/byte_num word.
//  One-shot per message, like the core: after the last word is accepted the block idles in DONE until reset.
// PARAMETERS
//  LEN_W  32  width of the message byte counter msg_len; it wraps modulo 2^LEN_W.
// PORTS
//  clk          in   1      clock; all registers update on the rising edge
//  reset        in   1      asynchronous, active-high; clears all state
//  s_byte       in   8      host message byte
//  s_valid      in   1      s_byte is valid
//  s_last       in   1      with s_valid: s_byte is the final byte of the message
//  s_end        in   1      ends the message with no byte attached (zero-length message or tail); ignored when s_valid=1
//  s_ready      out  1      block accepts s_valid or s_end this cycle
//  in           out  32     word to the core; first byte in [31:24]
//  in_ready     out  1      'in' is valid
//  is_last      out  1      the current word is the final one
//  byte_num     out  2      number of valid bytes in the final word (0..3); 0 when is_last=0
//  buffer_full  in   1      core cannot take a word this cycle
//  busy         out  1      message in progress (state != IDLE and state != DONE)
//  done         out  1      final word accepted; held until reset
//  msg_len      out  LEN_W  bytes accepted so far
// BEHAVIOUR
//  Reset values: in=0, in_ready=0, is_last=0, byte_num=0, s_ready=0 while reset is high, busy=0, done=0, msg_len=0.
//    Internal: pack reg pk[23:0]=0, cnt=0, state=IDLE.
//  Transfer to the core = in_ready & ~buffer_full, sampled at the clock edge.
//    While in_ready=1 and the word is not taken, in/is_last/byte_num hold stable.
//    in_ready drops in the cycle after the transfer unless a follow-up word is queued.
//  s_ready = (state==IDLE or COLLECT) & ~in_ready. Host accept = s_ready & (s_valid | s_end).
//  States:
//    IDLE -> COLLECT on the first accept (the accepted byte or end is processed as in COLLECT).
//    COLLECT, byte accepted, s_last=0:
//      cnt<3: pk gets the byte at position cnt; cnt++.
//      cnt==3: in={pk,s_byte}, in_ready=1, is_last=0, cnt=0, state SEND.
//    COLLECT, byte accepted, s_last=1, n=cnt+1 bytes held:
//      n<4: in = bytes left-aligned with unused low bytes zero; in_ready=1, is_last=1, byte_num=n; state SEND_LAST.
//      n==4: emit the full word with is_last=0; state SEND_FULL; after its transfer emit in=0, is_last=1, byte_num=0; state SEND_LAST.
//    COLLECT or IDLE, s_end accepted: in = held bytes left-aligned and zero-filled; is_last=1, byte_num=cnt; state SEND_LAST.
//      cnt==0 gives the empty last word.
//    SEND -> COLLECT on transfer.
//    SEND_FULL -> SEND_LAST on transfer; the next word is presented in the following cycle.
//    SEND_LAST -> DONE on transfer; in_ready=0 and done=1 from the next cycle.
//    DONE: s_ready=0, all host inputs ignored, in_ready=0. Only reset leaves DONE.
//  msg_len increments by 1 on every accepted byte (not on s_end).
//  Host latency: a 4th byte accepted at edge k gives in_ready=1 after edge k; at best 4 bytes per 5 cycles.
//  buffer_full may rise at any time. A word already presented stays presented; the block never withdraws in_ready before its transfer.
//  s_valid and s_end both high: the byte takes priority and s_end is ignored.
//  Reset asserted mid-message or mid-word: everything clears immediately and the pending word is dropped.
//    The core shares this reset, so both restart together.
// TESTING
//  T1 bytes "abc" with s_last on 'c' -> one word in=0x61626300, is_last=1, byte_num=3; then done=1, msg_len=3.
//  T2 s_end only, no bytes -> one word in=0, is_last=1, byte_num=0; done=1, msg_len=0.
//  T3 8 bytes 0x00..0x07 with s_last on 0x07 -> 0x00010203 (is_last=0), 0x04050607 (is_last=0), then 0x00000000 (is_last=1, byte_num=0).
//  T4 buffer_full=1 for 10 cycles while a word is pending -> in/in_ready/is_last/byte_num stable and s_ready=0 throughout; one transfer after release.
//  T5 5 bytes, then s_valid and s_end high together on the 6th byte 0xAA with s_last=1 -> byte wins: 0xAA is the 2nd byte of a 2-byte last word, byte_num=2.
//  T6 reset pulse after 2 bytes of a message, then "a" with s_last -> only in=0x61000000, is_last=1, byte_num=1 is emitted; msg_len=1.

Source files
------------

// File: rtl/keccak_feeder_if.sv
// keccak_feeder_if: host byte stream and core word bus in one bundle.
// master = host/core side driver, slave = the feeder itself.
//   s_byte/s_valid/s_last/s_end -> feeder, s_ready <- feeder
//   in/in_ready/is_last/byte_num <- feeder, buffer_full -> feeder
interface keccak_feeder_if;
  logic [7:0]  s_byte;
  logic        s_valid;
  logic        s_last;
  logic        s_end;
  logic        s_ready;
  logic [31:0] in;
  logic        in_ready;
  logic        is_last;
  logic [1:0]  byte_num;
  logic        buffer_full;

  modport slave (
    input  s_byte, s_valid, s_last, s_end,
    input  buffer_full,
    output s_ready,
    output in, in_ready, is_last, byte_num
  );

  modport master (
    output s_byte, s_valid, s_last, s_end,
    output buffer_full,
    input  s_ready,
    input  in, in_ready, is_last, byte_num
  );
endinterface

// File: rtl/keccak_feeder.sv
// keccak_feeder: packs a host byte stream big-endian into 32-bit
// words for the keccak core and closes the message with is_last.
// Ports: clk, reset (async, active-high), bus (slave view of the
//   byte stream and core word bus), busy, done, msg_len.
module keccak_feeder #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  keccak_feeder_if.slave   bus,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] msg_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND,
    S_SEND_FULL,
    S_SEND_LAST,
    S_DONE
  } state_t;

  state_t           r_state, w_state_n;
  logic [23:0]      r_pk, w_pk_n;
  logic [1:0]       r_cnt, w_cnt_n;
  logic [31:0]      r_in, w_in_n;
  logic             r_in_ready, w_in_ready_n;
  logic             r_is_last, w_is_last_n;
  logic [1:0]       r_byte_num, w_byte_num_n;
  logic             r_done, w_done_n;
  logic [LEN_W-1:0] r_len, w_len_n;

  logic        w_open;
  logic        w_s_ready;
  logic        w_acc_b;
  logic        w_acc_e;
  logic        w_xfer;
  logic [4:0]  w_sh;
  logic [31:0] w_word;

  assign w_open = (r_state == S_IDLE) |
                  (r_state == S_COLLECT);
  assign w_s_ready = w_open & ~r_in_ready & ~reset;
  // A byte always wins over a simultaneous s_end.
  assign w_acc_b = w_s_ready & bus.s_valid;
  assign w_acc_e = w_s_ready & ~bus.s_valid & bus.s_end;
  assign w_xfer  = r_in_ready & ~bus.buffer_full;

  // Byte slot cnt sits at bit 8*(3-cnt); 3-cnt == ~cnt.
  assign w_sh   = {~r_cnt, 3'b000};
  assign w_word = {r_pk, 8'h00} |
                  ({24'h0, bus.s_byte} << w_sh);

  always_comb begin
    w_state_n    = r_state;
    w_pk_n       = r_pk;
    w_cnt_n      = r_cnt;
    w_in_n       = r_in;
    w_in_ready_n = r_in_ready;
    w_is_last_n  = r_is_last;
    w_byte_num_n = r_byte_num;
    w_done_n     = r_done;
    w_len_n      = r_len;
    unique case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_acc_b) begin
          w_len_n   = r_len + LEN_W'(1);
          w_state_n = S_COLLECT;
          if (!bus.s_last && r_cnt != 2'd3) begin
            w_pk_n  = w_word[31:8];
            w_cnt_n = r_cnt + 2'd1;
          end else begin
            w_in_n       = w_word;
            w_in_ready_n = 1'b1;
            w_pk_n       = '0;
            w_cnt_n      = '0;
            w_is_last_n  = 1'b0;
            w_byte_num_n = '0;
            if (!bus.s_last) begin
              w_state_n = S_SEND;
            end else if (r_cnt == 2'd3) begin
              // Full last word: empty closing word follows.
              w_state_n = S_SEND_FULL;
            end else begin
              w_is_last_n  = 1'b1;
              w_byte_num_n = r_cnt + 2'd1;
              w_state_n    = S_SEND_LAST;
            end
          end
        end else if (w_acc_e) begin
          w_in_n       = {r_pk, 8'h00};
          w_in_ready_n = 1'b1;
          w_is_last_n  = 1'b1;
          w_byte_num_n = r_cnt;
          w_pk_n       = '0;
          w_cnt_n      = '0;
          w_state_n    = S_SEND_LAST;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          w_in_ready_n = 1'b0;
          w_state_n    = S_COLLECT;
        end
      end
      S_SEND_FULL: begin
        if (w_xfer) begin
          // in_ready stays high for the closing word.
          w_in_n       = '0;
          w_is_last_n  = 1'b1;
          w_byte_num_n = '0;
          w_state_n    = S_SEND_LAST;
        end
      end
      S_SEND_LAST: begin
        if (w_xfer) begin
          w_in_n       = '0;
          w_in_ready_n = 1'b0;
          w_is_last_n  = 1'b0;
          w_byte_num_n = '0;
          w_done_n     = 1'b1;
          w_state_n    = S_DONE;
        end
      end
      S_DONE: begin
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pk       <= '0;
      r_cnt      <= '0;
      r_in       <= '0;
      r_in_ready <= 1'b0;
      r_is_last  <= 1'b0;
      r_byte_num <= '0;
      r_done     <= 1'b0;
      r_len      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pk       <= w_pk_n;
      r_cnt      <= w_cnt_n;
      r_in       <= w_in_n;
      r_in_ready <= w_in_ready_n;
      r_is_last  <= w_is_last_n;
      r_byte_num <= w_byte_num_n;
      r_done     <= w_done_n;
      r_len      <= w_len_n;
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.in       = r_in;
  assign bus.in_ready = r_in_ready;
  assign bus.is_last  = r_is_last;
  assign bus.byte_num = r_byte_num;
  assign busy    = ~((r_state == S_IDLE) |
                     (r_state == S_DONE));
  assign done    = r_done;
  assign msg_len = r_len;

endmodule

// File: tb/tb_keccak_feeder.sv
// tb_keccak_feeder: random and directed messages checked against
// a word-list model of the expected core traffic.
module tb_keccak_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] msg_len;

  always #5 clk = ~clk;

  keccak_feeder_if bif();

  keccak_feeder #(.LEN_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bif),
    .busy    (busy),
    .done    (done),
    .msg_len (msg_len)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        l;
    logic [1:0]  n;
  } word_t;

  word_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    bf_mode = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  function automatic word_t mk(input logic [31:0] w,
                               input logic l,
                               input logic [1:0] n);
    word_t r;
    r.w = w;
    r.l = l;
    r.n = n;
    return r;
  endfunction

  // Any message of L bytes: L/4 full words, then one last
  // word holding the L%4 leftover bytes left-aligned.
  task automatic model(input logic [7:0] m[$]);
    int          len;
    int          r;
    logic [31:0] w;
    len = m.size();
    for (int k = 0; k < len / 4; k++) begin
      w = {m[4*k], m[4*k+1], m[4*k+2], m[4*k+3]};
      exp_q.push_back(mk(w, 1'b0, 2'd0));
    end
    r = len % 4;
    w = '0;
    for (int j = 0; j < r; j++)
      w[31-8*j -: 8] = m[4*(len/4)+j];
    exp_q.push_back(mk(w, 1'b1, 2'(r)));
  endtask

  // Core side: stall randomly or as forced.
  initial begin
    bif.buffer_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bf_mode)
        0: bif.buffer_full = 1'b0;
        1: bif.buffer_full = 1'b1;
        default:
          bif.buffer_full = ($urandom_range(0, 99) < 35);
      endcase
    end
  end

  // Compare process: every transfer against the model queue,
  // plus hold-stable and handshake rules each cycle.
  logic  pend = 1'b0;
  word_t prev;
  word_t cur;
  word_t ew;
  initial begin
    forever begin
      @(negedge clk);
      cur = mk(bif.in, bif.is_last, bif.byte_num);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend)
          chk("hold_stable", 64'(cur), 64'(prev));
        if (bif.in_ready) begin
          chk("s_ready_low", 64'(bif.s_ready), 64'(0));
          if (!bif.is_last)
            chk("byte_num_zero", 64'(bif.byte_num), 64'(0));
        end
        if (done)
          chk("done_no_word", 64'(bif.in_ready), 64'(0));
        if (bif.in_ready && !bif.buffer_full) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h want none",
                     cur);
          end else begin
            ew = exp_q.pop_front();
            chk("word", 64'(cur), 64'(ew));
          end
        end
        pend = bif.in_ready && bif.buffer_full;
        prev = cur;
      end
    end
  end

  task automatic idle_in();
    bif.s_valid = 1'b0;
    bif.s_byte  = 8'h00;
    bif.s_last  = 1'b0;
    bif.s_end   = 1'b0;
  endtask

  // One host item, held until accepted (bounded).
  task automatic put(input logic v, input logic [7:0] b,
                     input logic l, input logic e,
                     input int gap);
    bit acc;
    int t;
    for (int i = 0; i < gap; i++) begin
      idle_in();
      @(posedge clk);
      #1;
    end
    bif.s_valid = v;
    bif.s_byte  = b;
    bif.s_last  = l;
    bif.s_end   = e;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = bif.s_ready;
      @(posedge clk);
      #1;
      t++;
    end
    idle_in();
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL host_timeout: got no accept want accept");
    end
  endtask

  task automatic send_msg(input logic [7:0] m[$],
                          input bit tail_end,
                          input bit both_last,
                          input int gmax);
    bit   lst;
    logic e;
    for (int i = 0; i < m.size(); i++) begin
      lst = !tail_end && (i == m.size() - 1);
      // s_end alongside a byte must be ignored.
      e = lst ? both_last : ($urandom_range(0, 3) == 0);
      put(1'b1, m[i], lst, e, $urandom_range(0, gmax));
    end
    if (tail_end)
      put(1'b0, 8'h00, 1'b0, 1'b1, $urandom_range(0, gmax));
  endtask

  task automatic reset_vals();
    chk("rst_in", 64'(bif.in), 64'(0));
    chk("rst_in_ready", 64'(bif.in_ready), 64'(0));
    chk("rst_is_last", 64'(bif.is_last), 64'(0));
    chk("rst_byte_num", 64'(bif.byte_num), 64'(0));
    chk("rst_s_ready", 64'(bif.s_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_msg_len", 64'(msg_len), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic finish_msg(input int len);
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done", 64'(done), 64'(1));
    chk("msg_len", 64'(msg_len), 64'(len));
    chk("busy_end", 64'(busy), 64'(0));
    chk("words_left", 64'(exp_q.size()), 64'(0));
    // DONE ignores the host entirely.
    bif.s_valid = 1'b1;
    bif.s_byte  = 8'h5A;
    bif.s_last  = 1'b1;
    bif.s_end   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_s_ready", 64'(bif.s_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    idle_in();
    chk("done_msg_len", 64'(msg_len), 64'(len));
    chk("done_held", 64'(done), 64'(1));
    do_reset();
  endtask

  logic [7:0] m[$];
  int         len;
  bit         tl;

  initial begin
    idle_in();
    reset = 1'b1;
    @(negedge clk);
    reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 64'(bif.s_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;

    // "abc"
    exp_q.push_back(mk(32'h61626300, 1'b1, 2'd3));
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0, 0);
    finish_msg(3);

    // empty message
    exp_q.push_back(mk(32'h0, 1'b1, 2'd0));
    m = '{};
    send_msg(m, 1'b1, 1'b0, 0);
    finish_msg(0);

    // 8 bytes, last on a word boundary
    exp_q.push_back(mk(32'h00010203, 1'b0, 2'd0));
    exp_q.push_back(mk(32'h04050607, 1'b0, 2'd0));
    exp_q.push_back(mk(32'h00000000, 1'b1, 2'd0));
    m = '{8'h00, 8'h01, 8'h02, 8'h03,
          8'h04, 8'h05, 8'h06, 8'h07};
    send_msg(m, 1'b0, 1'b0, 1);
    finish_msg(8);

    // core stalls 10 cycles on a pending word
    exp_q.push_back(mk(32'h11223344, 1'b0, 2'd0));
    exp_q.push_back(mk(32'h00000000, 1'b1, 2'd0));
    bf_mode = 1;
    put(1'b1, 8'h11, 1'b0, 1'b0, 0);
    put(1'b1, 8'h22, 1'b0, 1'b0, 0);
    put(1'b1, 8'h33, 1'b0, 1'b0, 0);
    put(1'b1, 8'h44, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bif.in_ready), 64'(1));
      chk("stall_in", 64'(bif.in), 64'(32'h11223344));
      @(posedge clk);
      #1;
    end
    chk("stall_words_left", 64'(exp_q.size()), 64'(2));
    bf_mode = 0;
    put(1'b0, 8'h00, 1'b0, 1'b1, 0);
    finish_msg(4);

    // byte and s_end together on the last byte
    exp_q.push_back(mk(32'h10111213, 1'b0, 2'd0));
    exp_q.push_back(mk(32'h14AA0000, 1'b1, 2'd2));
    m = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'hAA};
    send_msg(m, 1'b0, 1'b1, 0);
    finish_msg(6);

    // reset mid-message drops the partial word
    put(1'b1, 8'h55, 1'b0, 1'b0, 0);
    put(1'b1, 8'h66, 1'b0, 1'b0, 0);
    chk("mid_msg_len", 64'(msg_len), 64'(2));
    do_reset();
    exp_q.push_back(mk(32'h61000000, 1'b1, 2'd1));
    m = '{8'h61};
    send_msg(m, 1'b0, 1'b0, 0);
    finish_msg(1);

    // random messages against the model
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(0, 13);
      tl = (len == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bf_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
      m = '{};
      for (int i = 0; i < len; i++)
        m.push_back(8'($urandom_range(0, 255)));
      model(m);
      send_msg(m, tl, 1'($urandom_range(0, 1)), 2);
      finish_msg(len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
